// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined mux tree: select-mode encoding and
// elaboration-time helpers for sizing and checking the channel count.
package mux_pkg;

   typedef enum logic {
      MODE_DIRECT = 1'b0,
      MODE_SCAN   = 1'b1
   } sel_mode_e;

   function automatic int clog2_f(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/mux_tree_level.sv
// One level of the mux tree: N_NODES inputs pair up into N_NODES/2 outputs,
// steered by bit LEVEL of the carried select, with an optional stage register.
module mux_tree_level
   import mux_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int N_NODES = 8,
   parameter int SEL_W   = 3,
   parameter int LEVEL   = 0,
   parameter bit REG     = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  logic                             in_valid,
   input  logic [N_NODES*DATA_W-1:0]        in_data,
   input  logic [SEL_W-1:0]                 in_sel,
   output logic                             out_valid,
   output logic [(N_NODES/2)*DATA_W-1:0]    out_data,
   output logic [SEL_W-1:0]                 out_sel
);

   localparam int N_OUT = N_NODES / 2;

   logic [N_OUT*DATA_W-1:0] mux_data;

   always_comb begin
      mux_data = '0;
      for (int j = 0; j < N_OUT; j++) begin
         mux_data[j*DATA_W +: DATA_W] = in_sel[LEVEL] ? in_data[(2*j+1)*DATA_W +: DATA_W]
                                                      : in_data[(2*j)*DATA_W +: DATA_W];
      end
   end

   generate
      if (REG) begin : g_reg
         logic                    valid_d, valid_q;
         logic [N_OUT*DATA_W-1:0] data_d, data_q;
         logic [SEL_W-1:0]        sel_d, sel_q;

         // The whole stage freezes while downstream stalls.
         always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            sel_d   = sel_q;
            if (en) begin
               valid_d = in_valid;
               data_d  = mux_data;
               sel_d   = in_sel;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               valid_q <= 1'b0;
               data_q  <= '0;
               sel_q   <= '0;
            end else begin
               valid_q <= valid_d;
               data_q  <= data_d;
               sel_q   <= sel_d;
            end
         end

         assign out_valid = valid_q;
         assign out_data  = data_q;
         assign out_sel   = sel_q;
      end else begin : g_comb
         logic unused_ctrl;
         assign unused_ctrl = &{1'b0, clk, rst, en};

         assign out_valid = in_valid;
         assign out_data  = mux_data;
         assign out_sel   = in_sel;
      end
   endgenerate

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 channel selector with valid/ready handshake, global stall and
// an optional round-robin scan pointer as the select source.
module mux_tree_pipe
   import mux_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int N_IN   = 8,
   parameter bit PIPE   = 1'b1,
   localparam int SEL_W = (N_IN < 2) ? 1 : clog2_f(N_IN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_IN*DATA_W-1:0]   in_data,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     scan_en,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_sel,
   output logic                     out_valid,
   input  logic                     out_ready
);

   if (!is_pow2(N_IN)) begin : g_bad_n_in
      $error("mux_tree_pipe: N_IN=%0d must be a power of 2 and >= 2", N_IN);
   end

   sel_mode_e        mode;
   logic             stall;
   logic             accept;
   logic [SEL_W-1:0] esel;
   logic [SEL_W-1:0] scan_ptr_d, scan_ptr_q;

   assign mode     = scan_en ? MODE_SCAN : MODE_DIRECT;
   assign stall    = out_valid && !out_ready;
   assign in_ready = rst || !stall;
   assign accept   = in_valid && !stall;
   assign esel     = (mode == MODE_SCAN) ? scan_ptr_q : in_sel;

   // Pointer advances only on beats that actually consumed it; wrap is free
   // because N_IN is a power of 2.
   always_comb begin
      scan_ptr_d = scan_ptr_q;
      if (accept && (mode == MODE_SCAN)) scan_ptr_d = scan_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) scan_ptr_q <= '0;
      else     scan_ptr_q <= scan_ptr_d;
   end

   // With PIPE=0 only the last level registers, giving a single-cycle tree.
   for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
      localparam int NI = N_IN >> k;

      logic                        valid_i, valid_o;
      logic [NI*DATA_W-1:0]        data_i;
      logic [(NI/2)*DATA_W-1:0]    data_o;
      logic [SEL_W-1:0]            sel_i, sel_o;

      if (k == 0) begin : g_first
         assign valid_i = in_valid;
         assign data_i  = in_data;
         assign sel_i   = esel;
      end else begin : g_next
         assign valid_i = g_lvl[k-1].valid_o;
         assign data_i  = g_lvl[k-1].data_o;
         assign sel_i   = g_lvl[k-1].sel_o;
      end

      mux_tree_level #(
         .DATA_W  (DATA_W),
         .N_NODES (NI),
         .SEL_W   (SEL_W),
         .LEVEL   (k),
         .REG     (PIPE || (k == SEL_W - 1))
      ) u_level (
         .clk       (clk),
         .rst       (rst),
         .en        (!stall),
         .in_valid  (valid_i),
         .in_data   (data_i),
         .in_sel    (sel_i),
         .out_valid (valid_o),
         .out_data  (data_o),
         .out_sel   (sel_o)
      );
   end

   assign out_valid = g_lvl[SEL_W-1].valid_o;
   assign out_data  = g_lvl[SEL_W-1].data_o;
   assign out_sel   = g_lvl[SEL_W-1].sel_o;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: a per-cycle vector table for the 8-channel
// pipelined build, plus hand sequences for reset mid-flight and the PIPE=0 build.
module tb_mux_tree_pipe;

   typedef struct {
      logic       vld;
      logic [2:0] sel;
      logic       scan;
      logic       ordy;
      logic       exp_ovld;
      logic [2:0] exp_osel;
      logic       exp_irdy;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   logic        clk = 1'b0;
   logic        rst;

   logic [63:0] in_data8;
   logic [2:0]  in_sel8;
   logic        in_valid8, in_ready8, scan_en8;
   logic [7:0]  out_data8;
   logic [2:0]  out_sel8;
   logic        out_valid8, out_ready8;

   logic [1:0]  in_data2;
   logic [0:0]  in_sel2;
   logic        in_valid2, in_ready2, scan_en2;
   logic [0:0]  out_data2;
   logic [0:0]  out_sel2;
   logic        out_valid2, out_ready2;

   always #5 clk = ~clk;

   mux_tree_pipe #(.DATA_W(8), .N_IN(8), .PIPE(1'b1)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data8),
      .in_sel    (in_sel8),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .scan_en   (scan_en8),
      .out_data  (out_data8),
      .out_sel   (out_sel8),
      .out_valid (out_valid8),
      .out_ready (out_ready8)
   );

   mux_tree_pipe #(.DATA_W(1), .N_IN(2), .PIPE(1'b0)) u_dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data2),
      .in_sel    (in_sel2),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .scan_en   (scan_en2),
      .out_data  (out_data2),
      .out_sel   (out_sel2),
      .out_valid (out_valid2),
      .out_ready (out_ready2)
   );

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void pushVec(input int vld, input int sel, input int scan, input int ordy,
                                   input int eov, input int eos, input int eir);
      vec_t v;
      v.vld      = 1'(vld);
      v.sel      = 3'(sel);
      v.scan     = 1'(scan);
      v.ordy     = 1'(ordy);
      v.exp_ovld = 1'(eov);
      v.exp_osel = 3'(eos);
      v.exp_irdy = 1'(eir);
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input vec_t v);
      in_valid8  = v.vld;
      in_sel8    = v.sel;
      scan_en8   = v.scan;
      out_ready8 = v.ordy;
   endtask

   // Channel i carries 8'h11*i, so the expected data follows from the expected index.
   task automatic checkOutput(input vec_t v, input int row);
      checkValue($sformatf("row%0d out_valid", row), {31'b0, out_valid8}, {31'b0, v.exp_ovld});
      checkValue($sformatf("row%0d in_ready", row), {31'b0, in_ready8}, {31'b0, v.exp_irdy});
      if (v.exp_ovld) begin
         checkValue($sformatf("row%0d out_sel", row), {29'b0, out_sel8}, {29'b0, v.exp_osel});
         checkValue($sformatf("row%0d out_data", row), {24'b0, out_data8}, 32'(17 * int'(v.exp_osel)));
      end
   endtask

   task automatic stepPipe0(input int vld, input int sel, input int scan, input int ordy,
                            input int ev, input int ed, input int es, input string tag);
      @(negedge clk);
      in_valid2  = 1'(vld);
      in_sel2    = 1'(sel);
      scan_en2   = 1'(scan);
      out_ready2 = 1'(ordy);
      @(posedge clk);
      #1;
      checkValue({tag, " out_valid"}, {31'b0, out_valid2}, 32'(ev));
      if (ev != 0) begin
         checkValue({tag, " out_data"}, {31'b0, out_data2}, 32'(ed));
         checkValue({tag, " out_sel"}, {31'b0, out_sel2}, 32'(es));
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not reach the end");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = 8'(17 * i);
      in_data2   = 2'b10;
      rst        = 1'b1;
      in_valid8  = 1'b0; in_sel8 = '0; scan_en8 = 1'b0; out_ready8 = 1'b1;
      in_valid2  = 1'b0; in_sel2 = '0; scan_en2 = 1'b0; out_ready2 = 1'b1;

      // Direct select 0..7 back-to-back, three flush cycles.
      for (int r = 0; r < 11; r++) pushVec(r < 8, r, 0, 1, r >= 3, r - 3, 1);
      // Scan mode for 10 beats; in_sel held at a value that must be ignored.
      for (int r = 0; r < 13; r++) pushVec(r < 10, 5, 1, 1, r >= 3, r - 3, 1);
      // out_ready low for 4 cycles mid-stream.
      pushVec(1, 0, 0, 1, 0, 0, 1);
      pushVec(1, 1, 0, 1, 0, 0, 1);
      pushVec(1, 2, 0, 1, 0, 0, 1);
      pushVec(1, 3, 0, 1, 1, 0, 1);
      pushVec(1, 4, 0, 0, 1, 1, 0);
      pushVec(1, 4, 0, 0, 1, 1, 0);
      pushVec(1, 4, 0, 0, 1, 1, 0);
      pushVec(1, 4, 0, 0, 1, 1, 0);
      pushVec(1, 4, 0, 1, 1, 1, 1);
      pushVec(1, 5, 0, 1, 1, 2, 1);
      pushVec(0, 0, 0, 1, 1, 3, 1);
      pushVec(0, 0, 0, 1, 1, 4, 1);
      pushVec(0, 0, 0, 1, 1, 5, 1);
      pushVec(0, 0, 0, 1, 0, 0, 1);
      // Gapped scan beats starting from scan_ptr=2; bubbles mirror the gaps.
      pushVec(1, 0, 1, 1, 0, 0, 1);
      pushVec(0, 0, 1, 1, 0, 0, 1);
      pushVec(1, 0, 1, 1, 0, 0, 1);
      pushVec(0, 0, 1, 1, 1, 2, 1);
      pushVec(1, 0, 1, 1, 0, 0, 1);
      pushVec(0, 0, 1, 1, 1, 3, 1);
      pushVec(0, 0, 1, 1, 0, 0, 1);
      pushVec(0, 0, 1, 1, 1, 4, 1);
      pushVec(0, 0, 1, 1, 0, 0, 1);

      repeat (2) @(negedge clk);
      checkValue("rst in_ready", {31'b0, in_ready8}, 32'd1);
      rst = 1'b0;
      #1;
      checkValue("reset out_valid", {31'b0, out_valid8}, 32'd0);
      checkValue("reset out_data", {24'b0, out_data8}, 32'd0);
      checkValue("reset out_sel", {29'b0, out_sel8}, 32'd0);
      checkValue("reset scan_ptr", {29'b0, u_dut8.scan_ptr_q}, 32'd0);
      checkValue("reset pipe0 out_valid", {31'b0, out_valid2}, 32'd0);

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput(vecs[i], i);
      end
      checkValue("gapped scan_ptr", {29'b0, u_dut8.scan_ptr_q}, 32'd5);

      // Reset with three beats in flight and the output stalled.
      @(negedge clk); in_valid8 = 1'b1; scan_en8 = 1'b1; out_ready8 = 1'b1;
      @(negedge clk);
      @(negedge clk); scan_en8 = 1'b0; in_sel8 = 3'd1;
      @(negedge clk); in_valid8 = 1'b0; out_ready8 = 1'b0; rst = 1'b1;
      #1;
      checkValue("preflush out_valid", {31'b0, out_valid8}, 32'd1);
      checkValue("preflush out_sel", {29'b0, out_sel8}, 32'd5);
      checkValue("preflush scan_ptr", {29'b0, u_dut8.scan_ptr_q}, 32'd7);
      checkValue("rst stalled in_ready", {31'b0, in_ready8}, 32'd1);
      @(negedge clk); rst = 1'b0; out_ready8 = 1'b1; in_valid8 = 1'b1; in_sel8 = 3'd6;
      #1;
      checkValue("postrst out_valid", {31'b0, out_valid8}, 32'd0);
      checkValue("postrst out_data", {24'b0, out_data8}, 32'd0);
      checkValue("postrst out_sel", {29'b0, out_sel8}, 32'd0);
      checkValue("postrst scan_ptr", {29'b0, u_dut8.scan_ptr_q}, 32'd0);
      checkValue("postrst in_ready", {31'b0, in_ready8}, 32'd1);
      @(negedge clk); in_valid8 = 1'b0;
      #1;
      checkValue("postrst lat1 out_valid", {31'b0, out_valid8}, 32'd0);
      @(negedge clk);
      #1;
      checkValue("postrst lat2 out_valid", {31'b0, out_valid8}, 32'd0);
      @(negedge clk);
      #1;
      checkValue("postrst lat3 out_valid", {31'b0, out_valid8}, 32'd1);
      checkValue("postrst lat3 out_sel", {29'b0, out_sel8}, 32'd6);
      checkValue("postrst lat3 out_data", {24'b0, out_data8}, 32'h66);
      @(negedge clk);
      #1;
      checkValue("postrst drained out_valid", {31'b0, out_valid8}, 32'd0);

      // PIPE=0, N_IN=2, DATA_W=1: single-cycle latency and scan_en toggling.
      stepPipe0(1, 1, 0, 1, 1, 1, 1, "p0 direct1");
      stepPipe0(1, 0, 0, 1, 1, 0, 0, "p0 direct0");
      stepPipe0(1, 1, 1, 1, 1, 0, 0, "p0 scan0");
      stepPipe0(1, 0, 0, 1, 1, 0, 0, "p0 scanoff");
      checkValue("p0 held scan_ptr", {31'b0, u_dut2.scan_ptr_q}, 32'd1);
      stepPipe0(0, 0, 1, 1, 0, 0, 0, "p0 idle");
      checkValue("p0 idle scan_ptr", {31'b0, u_dut2.scan_ptr_q}, 32'd1);
      stepPipe0(1, 0, 1, 1, 1, 1, 1, "p0 scan1");
      stepPipe0(1, 0, 1, 1, 1, 0, 0, "p0 wrap");
      stepPipe0(1, 0, 1, 0, 1, 0, 0, "p0 stall");
      checkValue("p0 stall scan_ptr", {31'b0, u_dut2.scan_ptr_q}, 32'd1);
      stepPipe0(0, 0, 1, 1, 0, 0, 0, "p0 drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
